// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - show-ahead synchronous FIFO with fill level and programmable thresholds
// Define FIFO_ERR_EN to add sticky overflow/underflow flags and the err_clr input.
module fifo_level #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 2**ADDR_WIDTH-1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
`ifdef FIFO_ERR_EN
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_LVL    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL    = AE_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  // A write into a full FIFO still lands when the same edge pops the head.
  assign do_wr = wr && (!full || rd);
  assign do_rd = rd && !empty;

  assign empty        = (level == '0);
  assign full         = (level == DEPTH_LVL);
  assign almost_empty = (level <= AE_LVL);
  assign almost_full  = (level >= AF_LVL);
  assign r_data       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef FIFO_ERR_EN
  // Set wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr && full && !rd) || (overflow && !err_clr);
      underflow <= (rd && empty) || (underflow && !err_clr);
    end
  end
`endif

endmodule
